// File: rtl/min_max_job_scheduler_pkg.sv
// Shared constants, state encoding and helpers
// for the two-requester min/max job scheduler.
package min_max_job_scheduler_pkg;

  localparam int N_ELEM = 16;
  localparam int DW = 8;
  localparam int AW = $clog2(N_ELEM);
  localparam int TIMEOUT_DEF = 63;

  localparam int I_IDLE = 0;
  localparam int I_COPY = 1;
  localparam int I_START = 2;
  localparam int I_WAIT = 3;
  localparam int I_RESP = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_COPY  = 5'b00010,
    S_START = 5'b00100,
    S_WAIT  = 5'b01000,
    S_RESP  = 5'b10000
  } state_e;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;

  // Width of a counter able to hold 0..t.
  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/min_max_job_scheduler_if.sv
// Requester and finder signals of the scheduler;
// master is the scheduler side, slave the environment.
interface min_max_job_scheduler_if;
  import min_max_job_scheduler_pkg::*;

  logic  req0;
  logic  req1;
  data_t rd_data0;
  data_t rd_data1;
  addr_t rd_addr;
  logic  gnt0;
  logic  gnt1;
  logic  ack0;
  logic  ack1;
  logic  err;
  data_t max_out;
  data_t min_out;
  logic  busy;

  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  logic  fnd_start;
  logic  fnd_done;
  data_t fnd_max;
  data_t fnd_min;

  modport master (
    input  req0, req1,
    input  rd_data0, rd_data1,
    output rd_addr,
    output gnt0, gnt1,
    output ack0, ack1, err,
    output max_out, min_out,
    output busy,
    output mem_we, mem_addr, mem_wdata,
    output fnd_start,
    input  fnd_done, fnd_max, fnd_min
  );

  modport slave (
    output req0, req1,
    output rd_data0, rd_data1,
    input  rd_addr,
    input  gnt0, gnt1,
    input  ack0, ack1, err,
    input  max_out, min_out,
    input  busy,
    input  mem_we, mem_addr, mem_wdata,
    input  fnd_start,
    output fnd_done, fnd_max, fnd_min
  );

endinterface

// File: rtl/min_max_job_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant
// flag moves to whichever requester wins.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // last_q = 1 means requester 1 was served last
  logic last_q;
  logic last_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      if (req0_i && req1_i) begin
        gnt0_o = last_q;
        gnt1_o = !last_q;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0_o) begin
      last_d = 1'b0;
    end else if (gnt1_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/min_max_job_scheduler.sv
// Shares one min/max finder between two requesters:
// copy 16 bytes, start, wait for done, acknowledge.
module min_max_job_scheduler
  import min_max_job_scheduler_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk_i,
  input logic rst_i,
  min_max_job_scheduler_if.master bus
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam addr_t LAST = addr_t'(N_ELEM - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  state_e        state_d;
  addr_t         cnt_q;
  addr_t         cnt_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          gnt0_q;
  logic          gnt0_d;
  logic          gnt1_q;
  logic          gnt1_d;
  logic          err_q;
  logic          err_d;
  data_t         max_q;
  data_t         max_d;
  data_t         min_q;
  data_t         min_d;

  logic arb_en;
  logic arb_g0;
  logic arb_g1;
  logic in_copy;
  logic in_resp;

  assign arb_en = state_q[I_IDLE];

  rr_arbiter2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (arb_en),
    .req0_i (bus.req0),
    .req1_i (bus.req1),
    .gnt0_o (arb_g0),
    .gnt1_o (arb_g1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    err_d   = err_q;
    max_d   = max_q;
    min_d   = min_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (arb_g0 || arb_g1) begin
          gnt0_d  = arb_g0;
          gnt1_d  = arb_g1;
          cnt_d   = '0;
          state_d = S_COPY;
        end
      end
      state_q[I_COPY]: begin
        cnt_d = cnt_q + addr_t'(1);
        if (cnt_q == LAST) begin
          state_d = S_START;
        end
      end
      state_q[I_START]: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      state_q[I_WAIT]: begin
        if (bus.fnd_done) begin
          max_d   = bus.fnd_max;
          min_d   = bus.fnd_min;
          state_d = S_RESP;
        end else if (tcnt_q == TLAST) begin
          // results keep their previous values
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      state_q[I_RESP]: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      err_q   <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      err_q   <= err_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  assign in_copy = state_q[I_COPY];
  assign in_resp = state_q[I_RESP];

  assign bus.rd_addr   = in_copy ? cnt_q : '0;
  assign bus.mem_addr  = in_copy ? cnt_q : '0;
  assign bus.mem_we    = in_copy;
  assign bus.mem_wdata = !in_copy ? '0 :
                         gnt1_q ? bus.rd_data1 :
                         bus.rd_data0;
  assign bus.fnd_start = state_q[I_START];

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.ack0    = in_resp && gnt0_q;
  assign bus.ack1    = in_resp && gnt1_q;
  assign bus.err     = in_resp && err_q;
  assign bus.max_out = max_q;
  assign bus.min_out = min_q;
  assign bus.busy    = !state_q[I_IDLE];

endmodule

// File: tb/tb_min_max_job_scheduler.sv
// Randomized self-checking bench for the min/max
// job scheduler with a behavioural finder model.
module tb_min_max_job_scheduler;
  import min_max_job_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  min_max_job_scheduler_if bus ();

  min_max_job_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;

  logic [7:0] buf0 [16];
  logic [7:0] buf1 [16];
  logic r0 = 1'b0;
  logic r1 = 1'b0;

  assign bus.req0 = r0;
  assign bus.req1 = r1;
  assign bus.rd_data0 = buf0[bus.rd_addr];
  assign bus.rd_data1 = buf1[bus.rd_addr];

  // finder model: remembers written bytes, answers fnd_lat edges after start
  logic [7:0] fmem [16];
  int fnd_lat = 3;
  bit fnd_mute = 1'b0;
  int fcnt = 0;
  logic fdone = 1'b0;
  logic spur = 1'b0;
  logic [7:0] fmax = 8'h00;
  logic [7:0] fmin = 8'h00;

  assign bus.fnd_done = fdone | spur;
  assign bus.fnd_max = spur ? 8'h5A : fmax;
  assign bus.fnd_min = spur ? 8'hA5 : fmin;

  function automatic logic [7:0] arr_max(input logic [7:0] a [16]);
    logic [7:0] m;
    m = a[0];
    for (int i = 1; i < 16; i++) if (a[i] > m) m = a[i];
    return m;
  endfunction

  function automatic logic [7:0] arr_min(input logic [7:0] a [16]);
    logic [7:0] m;
    m = a[0];
    for (int i = 1; i < 16; i++) if (a[i] < m) m = a[i];
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= 0;
      fdone <= 1'b0;
    end else begin
      fdone <= 1'b0;
      if (bus.mem_we) fmem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.fnd_start) begin
        fcnt <= fnd_mute ? 0 : fnd_lat;
      end else if (fcnt > 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1) begin
          fdone <= 1'b1;
          fmax <= arr_max(fmem);
          fmin <= arr_min(fmem);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.gnt0 && bus.gnt1) begin
        fails++;
        $display("FAIL gnt_exclusive t=%0t got gnt0=1 gnt1=1 want at most one", $time);
      end
    end
  end

  // reference state: who was served last, last good results
  int last_gnt = 1;
  logic [7:0] hold_max = 8'h00;
  logic [7:0] hold_min = 8'h00;

  function automatic int pick();
    int w;
    if (r0 && r1) w = (last_gnt == 0) ? 1 : 0;
    else w = r0 ? 0 : 1;
    last_gnt = w;
    return w;
  endfunction

  task automatic do_job(input int who, input bit exp_err,
                        input bit spur_copy, input bit drop_wait,
                        input bit hold);
    logic [7:0] em;
    logic [7:0] en;
    logic [7:0] d;
    logic w0;
    logic w1;
    int n;
    int exp_n;
    w0 = (who == 0);
    w1 = (who == 1);
    if (exp_err) begin
      em = hold_max;
      en = hold_min;
    end else if (who == 1) begin
      em = arr_max(buf1);
      en = arr_min(buf1);
    end else begin
      em = arr_max(buf0);
      en = arr_min(buf0);
    end
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== {w0, w1, 1'b1}) begin
      fails++;
      $display("FAIL grant got gnt0=%b gnt1=%b busy=%b want gnt0=%b gnt1=%b busy=1",
               bus.gnt0, bus.gnt1, bus.busy, w0, w1);
    end
    for (int i = 0; i < 16; i++) begin
      d = (who == 1) ? buf1[i] : buf0[i];
      if (spur_copy && i == 5) spur = 1'b1;
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.rd_addr, bus.mem_wdata, bus.fnd_start}
          !== {1'b1, 4'(i), 4'(i), d, 1'b0}) begin
        fails++;
        $display("FAIL copy[%0d] got we=%b addr=%0d rd=%0d wd=%02h st=%b want we=1 addr=%0d wd=%02h st=0",
                 i, bus.mem_we, bus.mem_addr, bus.rd_addr, bus.mem_wdata, bus.fnd_start, i, d);
      end
      @(negedge clk);
      spur = 1'b0;
    end
    checks++;
    if ({bus.fnd_start, bus.mem_we, bus.busy} !== 3'b101) begin
      fails++;
      $display("FAIL start got st=%b we=%b busy=%b want st=1 we=0 busy=1",
               bus.fnd_start, bus.mem_we, bus.busy);
    end
    @(negedge clk);
    n = 0;
    while (!(bus.ack0 || bus.ack1) && n < 100) begin
      if (drop_wait && n == 2) begin
        if (who == 1) r1 = 1'b0;
        else r0 = 1'b0;
      end
      checks++;
      if ({bus.fnd_start, bus.mem_we, bus.busy} !== 3'b001) begin
        fails++;
        $display("FAIL wait_cycle got st=%b we=%b busy=%b want st=0 we=0 busy=1",
                 bus.fnd_start, bus.mem_we, bus.busy);
      end
      @(negedge clk);
      n++;
    end
    exp_n = exp_err ? 63 : fnd_lat + 1;
    checks++;
    if (n !== exp_n) begin
      fails++;
      $display("FAIL wait_len got %0d cycles want %0d", n, exp_n);
    end
    checks++;
    if ({bus.ack0, bus.ack1, bus.err, bus.max_out, bus.min_out, bus.gnt0, bus.gnt1}
        !== {w0, w1, exp_err, em, en, w0, w1}) begin
      fails++;
      $display("FAIL resp got ack0=%b ack1=%b err=%b max=%02h min=%02h want ack0=%b ack1=%b err=%b max=%02h min=%02h",
               bus.ack0, bus.ack1, bus.err, bus.max_out, bus.min_out,
               w0, w1, exp_err, em, en);
    end
    hold_max = em;
    hold_min = en;
    if (!hold) begin
      if (who == 1) r1 = 1'b0;
      else r0 = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.mem_we, bus.fnd_start}
        !== 8'h00) begin
      fails++;
      $display("FAIL idle_after got busy=%b gnt=%b%b ack=%b%b err=%b we=%b st=%b want all 0",
               bus.busy, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.mem_we, bus.fnd_start);
    end
  endtask

  task automatic serve(input bit exp_err, input bit spur_copy,
                       input bit drop_wait, input bit hold);
    int w;
    w = pick();
    @(negedge clk);
    do_job(w, exp_err, spur_copy, drop_wait, hold);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_gnt = 1;
    hold_max = 8'h00;
    hold_min = 8'h00;
  endtask

  task automatic rand_bufs();
    for (int i = 0; i < 16; i++) begin
      buf0[i] = 8'($urandom_range(0, 255));
      buf1[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.busy, bus.mem_we,
         bus.fnd_start, bus.rd_addr, bus.mem_addr, bus.mem_wdata,
         bus.max_out, bus.min_out} !== 40'h0) begin
      fails++;
      $display("FAIL reset_state got busy=%b gnt=%b%b max=%02h min=%02h want all 0",
               bus.busy, bus.gnt0, bus.gnt1, bus.max_out, bus.min_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.max_out, bus.min_out} !== 19'h0) begin
      fails++;
      $display("FAIL reset_release got busy=%b gnt=%b%b want 0", bus.busy, bus.gnt0, bus.gnt1);
    end
  endtask

  task automatic test_single();
    rand_bufs();
    for (int i = 4; i < 15; i++) buf0[i] = 8'($urandom_range(4, 199));
    buf0[0] = 8'd5;
    buf0[1] = 8'd9;
    buf0[2] = 8'd200;
    buf0[3] = 8'd3;
    buf0[15] = 8'd77;
    fnd_lat = 4;
    r0 = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_both_held();
    rand_bufs();
    fnd_lat = 6;
    r0 = 1'b1;
    r1 = 1'b1;
    for (int k = 0; k < 3; k++) serve(1'b0, 1'b0, 1'b0, 1'b1);
    r0 = 1'b0;
    r1 = 1'b0;
  endtask

  task automatic test_timeout();
    rand_bufs();
    fnd_mute = 1'b1;
    r1 = 1'b1;
    serve(1'b1, 1'b0, 1'b0, 1'b0);
    fnd_mute = 1'b0;
  endtask

  task automatic test_mid_reset();
    int w;
    rand_bufs();
    fnd_lat = 5;
    r0 = 1'b1;
    w = pick();
    repeat (8) @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b1, 4'd7}) begin
      fails++;
      $display("FAIL pre_reset got we=%b addr=%0d want we=1 addr=7", bus.mem_we, bus.mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_addr, bus.max_out, bus.min_out}
        !== 24'h0) begin
      fails++;
      $display("FAIL async_reset got busy=%b gnt0=%b we=%b addr=%0d want 0",
               bus.busy, bus.gnt0, bus.mem_we, bus.mem_addr);
    end
    r0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_gnt = 1;
    hold_max = 8'h00;
    hold_min = 8'h00;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
        fails++;
        $display("FAIL no_ack_after_reset got ack=%b%b busy=%b want 0", bus.ack0, bus.ack1, bus.busy);
      end
      @(negedge clk);
    end
    if (w != 0) $display("note: unexpected pick %0d", w);
    r0 = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 16; i++) begin
      buf0[i] = 8'hFF;
      buf1[i] = 8'h00;
    end
    fnd_lat = 2;
    r0 = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 1'b0);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if ({bus.busy, bus.max_out, bus.min_out} !== {1'b0, 8'hFF, 8'hFF}) begin
      fails++;
      $display("FAIL idle_done_ignored got busy=%b max=%02h min=%02h want busy=0 max=ff min=ff",
               bus.busy, bus.max_out, bus.min_out);
    end
    r1 = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_drop_wait();
    rand_bufs();
    fnd_lat = 10;
    r1 = 1'b1;
    serve(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      rand_bufs();
      fnd_lat = $urandom_range(1, 32);
      if (!r0 && $urandom_range(0, 1) == 1) r0 = 1'b1;
      if (!r1 && $urandom_range(0, 1) == 1) r1 = 1'b1;
      if (!r0 && !r1) begin
        if ($urandom_range(0, 1) == 1) r1 = 1'b1;
        else r0 = 1'b1;
      end
      serve(1'b0, 1'b0, 1'b0, 1'b0);
    end
    r0 = 1'b0;
    r1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_both_held();
    test_timeout();
    test_mid_reset();
    test_extremes();
    test_drop_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
